beat_sequencer: RTL
===================

# beat_sequencer

Record/playback controller for the note display path. It timestamps keyboard note events (7-bit ASCII) into an on-chip buffer while recording. On playback it replays them with the original inter-key spacing, driving the ASCII code into the key-to-7-segment decoder. It sits between the PS/2 keyboard front end and the note/symbol display decoder.

## Interface
- `DEPTH`, 32: number of recorded events; power of two, at least 2.
- `DELTA_W`, 12: width of the per-event delay field, in ticks.
- `TICK_DIV`, 50000: clock cycles per time tick (1 ms at 50 MHz); at least 2.
- `clock`  in  1  system clock; all state is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `rec_req`  in  1  single-cycle pulse that clears the buffer and starts recording.
- `play_req`  in  1  single-cycle pulse that starts playback from entry 0.
- `stop_req`  in  1  single-cycle pulse that aborts to IDLE.
- `key_valid`  in  1  one-cycle strobe qualifying `key_ascii`.
- `key_ascii`  in  7  ASCII code of the pressed key.
- `disp_ascii`  out  7  code forwarded to the display decoder.
- `disp_valid`  out  1  `disp_ascii` is meaningful.
- `recording`  out  1  high in RECORD.
- `playing`  out  1  high in any PLAY state.
- `mem_full`  out  1  `entry_count == DEPTH`.
- `entry_count`  out  clog2(DEPTH)+1  number of stored events.

## Operation
- States: IDLE, RECORD, PLAY_LOAD, PLAY_WAIT, PLAY_EMIT.
- Request priority in any cycle: stop_req > rec_req > play_req. A request that does not apply to the current state is ignored.
- **Prescaler**
  - Counts 0..TICK_DIV-1 and asserts internal `tick` in the cycle it equals TICK_DIV-1.
  - Cleared to 0 on entry to RECORD and on IDLE→PLAY_LOAD.
  - Holds at 0 in IDLE.
- **IDLE**
  - rec_req: entry_count←0, delta←0, go to RECORD.
  - play_req with entry_count>0: rd←0, go to PLAY_LOAD.
  - play_req with entry_count==0: ignored.
- **RECORD**
  - delta increments on each tick and saturates at 2^DELTA_W−1.
  - On key_valid with entry_count<DEPTH:
    - write {key_ascii, delta} to address entry_count;
    - entry_count++;
    - delta←0 (this wins over a same-cycle tick);
    - disp_ascii←key_ascii and disp_valid←1 (live echo).
  - When that write makes entry_count==DEPTH, go to IDLE in the same edge.
  - stop_req goes to IDLE and keeps the buffer.
  - rec_req and play_req are ignored in RECORD.
  - key_valid in the same cycle as the rec_req that enters RECORD is not recorded.
- **PLAY_LOAD**
  - Issue a synchronous read of entry rd.
  - wait_cnt←0.
  - Go to PLAY_WAIT.
- **PLAY_WAIT**
  - wait_cnt increments on tick.
  - When wait_cnt == entry delta, go to PLAY_EMIT. The comparison is evaluated before increment, so delta=0 leaves after one cycle.
- **PLAY_EMIT**
  - disp_ascii←entry ascii, disp_valid←1.
  - rd++.
  - If rd+1==entry_count, go to IDLE and disp_valid←0 one cycle later; otherwise go to PLAY_LOAD.
- stop_req in any PLAY state goes to IDLE, clears disp_valid, and keeps the buffer.
- key_valid outside RECORD is ignored.
- The buffer contents are not reset; only entry_count is.

## Timing
- Reset values:
  - disp_ascii=0, disp_valid=0, recording=0, playing=0, mem_full=0, entry_count=0;
  - state IDLE, prescaler 0.
- Output timing:
  - All outputs are registered.
  - recording and playing reflect the state one cycle after the transition edge.
- Record echo: disp_ascii updates on the edge that samples key_valid.
- Playback:
  - The first event is emitted delta0 ticks after play_req. PLAY_LOAD and PLAY_WAIT add a fixed 2-cycle overhead.
  - Each later event is emitted delta_i ticks, plus 3 cycles of overhead, after the previous one.
- Reset mid-operation aborts immediately to the reset values; the memory is untouched.
- entry_count wrap is impossible: writes are gated at DEPTH.

## Structure
- Shared include `beat_defs.vh` holds:
  - the state encodings;
  - the ASCII width (7);
  - entry field offsets {ascii[6:0], delta[DELTA_W-1:0]}.
- Sub-module `beat_mem`:
  - simple dual-port RAM of DEPTH × (7+DELTA_W);
  - synchronous write and synchronous read with 1-cycle latency;
  - no reset, so it infers to block RAM.
- The display decoder stays external; `disp_ascii` connects directly to its ASCII input.

## Test plan
The bench uses TICK_DIV=4.
- **Record three keys.** After reset, pulse rec_req, then key_valid with 81 ('Q'), 87 ('W') and 69 ('E'), each 20 ticks apart, then stop_req. Required: entry_count=3; stored deltas of the second and third keys are 20; disp_ascii=69 after the third key; recording returns to 0.
- **Playback of that recording.** Pulse play_req. Required: disp_ascii steps through 81, 87, 69 with 80±3 cycles between emits. playing falls to 0 and disp_valid to 0 after the last emit.
- **Fill.** Pulse rec_req, then DEPTH key strobes on consecutive cycles. Required: mem_full=1, return to IDLE automatically, and a further key_valid leaves entry_count=DEPTH.
- **Zero-delay and saturation.**
  - Two keys on adjacent cycles: the second entry has delta=0 and is emitted 3 cycles after the first on playback.
  - A 5000-tick gap with DELTA_W=12: the stored delta is 4095.
- **Priorities.**
  - rec_req and play_req in the same cycle from IDLE: RECORD is entered.
  - stop_req with play_req during PLAY_WAIT: IDLE, disp_valid=0.
  - play_req with entry_count=0: stays IDLE.
- **Async reset mid-playback.** Assert resetn=0 during PLAY_WAIT. Required: all outputs go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/beat_sequencer_pkg.sv
// Shared definitions for the beat sequencer slice.
//   ASCII_W : width of the key / display ASCII code.
//   state_t : controller state encoding.
// A buffer entry is packed as {ascii[ASCII_W-1:0], delta[DELTA_W-1:0]}, so the
// delta field always sits at bit 0 and the ASCII code starts at bit DELTA_W.
package beat_sequencer_pkg;

  localparam int ASCII_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY_LOAD,
    S_PLAY_WAIT,
    S_PLAY_EMIT
  } state_t;

endpackage

// File: rtl/beat_sequencer_if.sv
// Control/status bundle between the keyboard front end, the sequencer and the
// display decoder.
//   rec_req/play_req/stop_req : single-cycle command pulses
//   key_valid/key_ascii       : key strobe from the PS/2 front end
//   disp_valid/disp_ascii     : code forwarded to the display decoder
//   recording/playing         : registered state flags
//   mem_full/entry_count      : buffer occupancy
// Modport slave is the sequencer side, master is the controlling side.
interface beat_sequencer_if
  import beat_sequencer_pkg::*;
#(
  parameter int DEPTH = 32
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               rec_req;
  logic               play_req;
  logic               stop_req;
  logic               key_valid;
  logic [ASCII_W-1:0] key_ascii;
  logic [ASCII_W-1:0] disp_ascii;
  logic               disp_valid;
  logic               recording;
  logic               playing;
  logic               mem_full;
  logic [CNT_W-1:0]   entry_count;

  modport master (
    output rec_req, play_req, stop_req, key_valid, key_ascii,
    input  disp_ascii, disp_valid, recording, playing, mem_full, entry_count
  );

  modport slave (
    input  rec_req, play_req, stop_req, key_valid, key_ascii,
    output disp_ascii, disp_valid, recording, playing, mem_full, entry_count
  );

endinterface

// File: rtl/beat_mem.sv
// Event buffer: simple dual-port RAM, DEPTH x WIDTH.
//   clock        : write and read clock
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : synchronous read port, data valid one cycle after re
// Deliberately has no reset so it maps onto block RAM; contents survive a
// controller reset.
module beat_mem #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 19
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Record/playback controller for the note display path.
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : beat_sequencer_if.slave (commands, key strobe, display and status)
// While recording, each key is stored with the number of ticks since the
// previous key (saturating). Playback replays the entries, waiting the stored
// tick count before each one is forwarded to the display.
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int DELTA_W  = 12,
  parameter int TICK_DIV = 50000
) (
  input  logic             clock,
  input  logic             resetn,
  beat_sequencer_if.slave  bus
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int ENTRY_W = ASCII_W + DELTA_W;

  state_t               state_reg, state_next;
  logic [PRESC_W-1:0]   presc_reg, presc_next;
  logic [DELTA_W-1:0]   delta_reg, delta_next;
  logic [CNT_W-1:0]     count_reg, count_next;
  logic [ADDR_W-1:0]    rd_reg, rd_next;
  logic [DELTA_W-1:0]   wait_reg, wait_next;
  logic [ASCII_W-1:0]   disp_ascii_reg, disp_ascii_next;
  logic                 disp_valid_reg, disp_valid_next;
  logic                 recording_reg, playing_reg, mem_full_reg;

  logic                 tick;
  logic                 mem_we, mem_re;
  logic [ENTRY_W-1:0]   mem_wdata, mem_rdata;
  logic [DELTA_W-1:0]   entry_delta;
  logic [ASCII_W-1:0]   entry_ascii;
  logic [CNT_W-1:0]     rd_plus1;

  assign tick        = (presc_reg == PRESC_W'(TICK_DIV - 1));
  assign entry_delta = mem_rdata[DELTA_W-1:0];
  assign entry_ascii = mem_rdata[DELTA_W +: ASCII_W];
  assign rd_plus1    = {1'b0, rd_reg} + CNT_W'(1);
  assign mem_wdata   = {bus.key_ascii, delta_reg};
  // The read address is only sampled in PLAY_LOAD, so the data is stable
  // throughout PLAY_WAIT and PLAY_EMIT.
  assign mem_re      = (state_reg == S_PLAY_LOAD);

  beat_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (count_reg[ADDR_W-1:0]),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (rd_reg),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      presc_reg      <= '0;
      delta_reg      <= '0;
      count_reg      <= '0;
      rd_reg         <= '0;
      wait_reg       <= '0;
      disp_ascii_reg <= '0;
      disp_valid_reg <= 1'b0;
      recording_reg  <= 1'b0;
      playing_reg    <= 1'b0;
      mem_full_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      presc_reg      <= presc_next;
      delta_reg      <= delta_next;
      count_reg      <= count_next;
      rd_reg         <= rd_next;
      wait_reg       <= wait_next;
      disp_ascii_reg <= disp_ascii_next;
      disp_valid_reg <= disp_valid_next;
      // Status flags follow the state register, so they lag a transition by
      // one cycle.
      recording_reg  <= (state_reg == S_RECORD);
      playing_reg    <= (state_reg == S_PLAY_LOAD) || (state_reg == S_PLAY_WAIT) ||
                        (state_reg == S_PLAY_EMIT);
      mem_full_reg   <= (count_next == CNT_W'(DEPTH));
    end
  end

  always_comb begin
    state_next      = state_reg;
    presc_next      = presc_reg;
    delta_next      = delta_reg;
    count_next      = count_reg;
    rd_next         = rd_reg;
    wait_next       = wait_reg;
    disp_ascii_next = disp_ascii_reg;
    disp_valid_next = disp_valid_reg;
    mem_we          = 1'b0;

    // Prescaler parks at 0 in IDLE, so every RECORD/PLAY session starts on a
    // fresh tick phase.
    if (state_reg == S_IDLE || tick) begin
      presc_next = '0;
    end else begin
      presc_next = presc_reg + PRESC_W'(1);
    end

    case (state_reg)
      S_IDLE: begin
        disp_valid_next = 1'b0;
        if (!bus.stop_req) begin
          if (bus.rec_req) begin
            count_next = '0;
            delta_next = '0;
            presc_next = '0;
            state_next = S_RECORD;
          end else if (bus.play_req && count_reg != '0) begin
            rd_next    = '0;
            presc_next = '0;
            state_next = S_PLAY_LOAD;
          end
        end
      end

      S_RECORD: begin
        if (bus.stop_req) begin
          state_next = S_IDLE;
        end else begin
          if (tick && delta_reg != '1) begin
            delta_next = delta_reg + DELTA_W'(1);
          end
          if (bus.key_valid && count_reg < CNT_W'(DEPTH)) begin
            mem_we          = 1'b1;
            count_next      = count_reg + CNT_W'(1);
            delta_next      = '0;   // overrides a same-cycle tick increment
            disp_ascii_next = bus.key_ascii;
            disp_valid_next = 1'b1;
            if (count_reg + CNT_W'(1) == CNT_W'(DEPTH)) begin
              state_next = S_IDLE;
            end
          end
        end
      end

      S_PLAY_LOAD: begin
        if (bus.stop_req) begin
          disp_valid_next = 1'b0;
          state_next      = S_IDLE;
        end else begin
          wait_next  = '0;
          state_next = S_PLAY_WAIT;
        end
      end

      S_PLAY_WAIT: begin
        if (bus.stop_req) begin
          disp_valid_next = 1'b0;
          state_next      = S_IDLE;
        end else if (wait_reg == entry_delta) begin
          state_next = S_PLAY_EMIT;
        end else if (tick) begin
          wait_next = wait_reg + DELTA_W'(1);
        end
      end

      S_PLAY_EMIT: begin
        if (bus.stop_req) begin
          disp_valid_next = 1'b0;
          state_next      = S_IDLE;
        end else begin
          disp_ascii_next = entry_ascii;
          disp_valid_next = 1'b1;
          rd_next         = rd_reg + ADDR_W'(1);
          // disp_valid is dropped by IDLE on the following edge.
          state_next      = (rd_plus1 == count_reg) ? S_IDLE : S_PLAY_LOAD;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.disp_ascii  = disp_ascii_reg;
  assign bus.disp_valid  = disp_valid_reg;
  assign bus.recording   = recording_reg;
  assign bus.playing     = playing_reg;
  assign bus.mem_full    = mem_full_reg;
  assign bus.entry_count = count_reg;

endmodule
